// File: rtl/memoria_instrucoes_param_pkg.sv
// Shared widths and field constants for the Redux-V fetch path.
package memoria_instrucoes_param_pkg;

    localparam int unsigned LARGURA_DADO_PADRAO = 8;
    localparam int unsigned LARGURA_END_PADRAO  = 8;
    localparam int unsigned PROFUNDIDADE_PADRAO = 256;

    // Opcode field position inside an instruction word, consumed by decode
    localparam int unsigned OPCODE_MSB = 7;
    localparam int unsigned OPCODE_LSB = 4;

    typedef enum logic {
        RESP_VAZIO = 1'b0,
        RESP_CHEIO = 1'b1
    } estado_resp_t;

endpackage

// File: rtl/memoria_instrucoes_banco.sv
// Storage array with per-word loaded flags and a write-first read mux.
module memoria_instrucoes_banco #(
    parameter int unsigned LARGURA_DADO = 8,
    parameter int unsigned LARGURA_END  = 8,
    parameter int unsigned PROFUNDIDADE = 256
) (
    input  logic                    clock,
    input  logic                    limpar,
    input  logic                    escrita_en,
    input  logic [LARGURA_END-1:0]  escrita_end,
    input  logic [LARGURA_DADO-1:0] escrita_dado,
    input  logic [LARGURA_END-1:0]  leitura_end,
    output logic [LARGURA_DADO-1:0] leitura_dado,
    output logic                    leitura_carregada,
    output logic                    palavra_nova
);

    localparam int unsigned IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

    logic [LARGURA_DADO-1:0] mem [PROFUNDIDADE];
    logic [PROFUNDIDADE-1:0] carregado;
    logic [IW-1:0]           idx_escrita;
    logic [IW-1:0]           idx_leitura;
    logic                    mesmo_end;

    assign idx_escrita = IW'(escrita_end);
    assign idx_leitura = IW'(leitura_end);
    assign mesmo_end   = escrita_en && (escrita_end == leitura_end);

    // Data is written even when limpar wins over the flag update
    always_ff @(posedge clock) begin
        if (escrita_en) begin
            mem[idx_escrita] <= escrita_dado;
        end
    end

    always_ff @(posedge clock) begin
        if (limpar) begin
            carregado <= '0;
        end else if (escrita_en) begin
            carregado[idx_escrita] <= 1'b1;
        end
    end

    // Write-first: a same-cycle load is visible to the read
    always_comb begin
        leitura_dado      = mesmo_end ? escrita_dado : mem[idx_leitura];
        leitura_carregada = !limpar && (mesmo_end || carregado[idx_leitura]);
        palavra_nova      = escrita_en && !limpar && !carregado[idx_escrita];
    end

endmodule

// File: rtl/memoria_instrucoes_param.sv
// Synchronous-read instruction memory with valid/ready fetch and a program-load port.
module memoria_instrucoes_param
    import memoria_instrucoes_param_pkg::*;
#(
    parameter int unsigned LARGURA_DADO = LARGURA_DADO_PADRAO,
    parameter int unsigned LARGURA_END  = LARGURA_END_PADRAO,
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valido,
    output logic                    req_pronto,
    input  logic [LARGURA_END-1:0]  endereco,
    output logic                    resp_valido,
    input  logic                    resp_pronto,
    output logic [LARGURA_DADO-1:0] instrucao,
    output logic                    fim_programa,
    output logic                    erro_end,
    input  logic                    carga_en,
    input  logic [LARGURA_END-1:0]  carga_end,
    input  logic [LARGURA_DADO-1:0] carga_dado,
    input  logic                    limpar,
    output logic [LARGURA_END:0]    num_palavras
);

    localparam logic [LARGURA_END:0] LIMITE = (LARGURA_END + 1)'(PROFUNDIDADE);

    estado_resp_t            estado;
    logic                    aceita;
    logic                    fetch_ok;
    logic                    carga_ok;
    logic [LARGURA_DADO-1:0] dado_lido;
    logic                    carregada;
    logic                    palavra_nova;

    assign fetch_ok    = {1'b0, endereco} < LIMITE;
    assign carga_ok    = {1'b0, carga_end} < LIMITE;
    assign resp_valido = (estado == RESP_CHEIO);
    assign req_pronto  = !resp_valido || resp_pronto;
    assign aceita      = req_valido && req_pronto;

    memoria_instrucoes_banco #(
        .LARGURA_DADO (LARGURA_DADO),
        .LARGURA_END  (LARGURA_END),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_banco (
        .clock             (clock),
        .limpar            (limpar),
        .escrita_en        (carga_en && carga_ok),
        .escrita_end       (carga_end),
        .escrita_dado      (carga_dado),
        .leitura_end       (endereco),
        .leitura_dado      (dado_lido),
        .leitura_carregada (carregada),
        .palavra_nova      (palavra_nova)
    );

    // Response register: EMPTY/FULL, reset drops any in-flight response
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= RESP_VAZIO;
            instrucao    <= '0;
            fim_programa <= 1'b0;
            erro_end     <= 1'b0;
        end else if (aceita) begin
            estado       <= RESP_CHEIO;
            instrucao    <= (fetch_ok && carregada) ? dado_lido : '0;
            fim_programa <= !(fetch_ok && carregada);
            erro_end     <= !fetch_ok;
        end else if (estado == RESP_CHEIO && resp_pronto) begin
            estado <= RESP_VAZIO;
        end
    end

    // Word count survives reset; only limpar clears it
    always_ff @(posedge clock) begin
        if (limpar) begin
            num_palavras <= '0;
        end else if (palavra_nova) begin
            num_palavras <= num_palavras + (LARGURA_END + 1)'(1);
        end
    end

endmodule
